// File: rtl/exec_stage_unit.sv
// exec_stage_unit: MIPS execute stage (ID/EX capture, forwarding, ALU, branch, EX/MEM, load-use stall).
// Define EXEC_OVF_EN to flag signed ADD/SUB overflow on ovf_87 and suppress that write-back.
module exec_stage_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk_87,
  input  logic              rst_87,
  input  logic              id_reg_write_87,
  input  logic              id_mem_to_reg_87,
  input  logic              id_mem_read_87,
  input  logic              id_mem_write_87,
  input  logic              id_alu_src_87,
  input  logic              id_branch_87,
  input  logic [3:0]        id_alu_op_87,
  input  logic [DATA_W-1:0] id_data_1_87,
  input  logic [DATA_W-1:0] id_data_2_87,
  input  logic [DATA_W-1:0] id_immd_87,
  input  logic [ADDR_W-1:0] id_pc_87,
  input  logic [REG_W-1:0]  id_rs_87,
  input  logic [REG_W-1:0]  id_rt_87,
  input  logic [REG_W-1:0]  id_wreg_87,
  input  logic              flush_87,
  input  logic              wb_en_87,
  input  logic [REG_W-1:0]  wb_reg_87,
  input  logic [DATA_W-1:0] wb_data_87,
  output logic              stall_87,
  output logic [DATA_W-1:0] ex_alu_result_87,
  output logic [DATA_W-1:0] ex_store_data_87,
  output logic [REG_W-1:0]  ex_wreg_87,
  output logic              ex_reg_write_87,
  output logic              ex_mem_to_reg_87,
  output logic              ex_mem_read_87,
  output logic              ex_mem_write_87,
  output logic              ex_br_taken_87,
  output logic [ADDR_W-1:0] ex_br_target_87,
  output logic              ovf_87
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100;
  typedef struct packed {
    logic              reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] data_1, data_2, immd;
    logic [ADDR_W-1:0] pc;
    logic [REG_W-1:0]  rs, rt, wreg;
  } idex_t;
  idex_t r_idex, w_idex_d;
  logic              w_wb_ok, w_ex_ok, w_eq, w_slt;
  logic [DATA_W-1:0] w_fwd_a, w_fwd_b, w_alu_b, w_sum, w_diff, w_alu;
  assign w_wb_ok = wb_en_87 && wb_reg_87 != '0;
  assign w_ex_ok = ex_reg_write_87 && !ex_mem_to_reg_87 && ex_wreg_87 != '0;
  assign stall_87 = r_idex.mem_read && r_idex.wreg != '0 &&
                    (r_idex.wreg == id_rs_87 || r_idex.wreg == id_rt_87);
  // Register-file write-through: a same-cycle MEM/WB write overrides the stale read data.
  always_comb begin
    w_idex_d = '{reg_write: id_reg_write_87, mem_to_reg: id_mem_to_reg_87,
                 mem_read: id_mem_read_87, mem_write: id_mem_write_87,
                 alu_src: id_alu_src_87, branch: id_branch_87, alu_op: id_alu_op_87,
                 data_1: (w_wb_ok && wb_reg_87 == id_rs_87) ? wb_data_87 : id_data_1_87,
                 data_2: (w_wb_ok && wb_reg_87 == id_rt_87) ? wb_data_87 : id_data_2_87,
                 immd: id_immd_87, pc: id_pc_87, rs: id_rs_87, rt: id_rt_87, wreg: id_wreg_87};
  end
  always_ff @(posedge clk_87 or negedge rst_87)
    if (!rst_87) r_idex <= '0;
    else r_idex <= (stall_87 || flush_87) ? '0 : w_idex_d;
  // Loads in EX/MEM have no data yet, so only ALU results are forwarded from there.
  assign w_fwd_a = (w_ex_ok && ex_wreg_87 == r_idex.rs) ? ex_alu_result_87 :
                   (w_wb_ok && wb_reg_87 == r_idex.rs) ? wb_data_87 : r_idex.data_1;
  assign w_fwd_b = (w_ex_ok && ex_wreg_87 == r_idex.rt) ? ex_alu_result_87 :
                   (w_wb_ok && wb_reg_87 == r_idex.rt) ? wb_data_87 : r_idex.data_2;
  assign w_alu_b = r_idex.alu_src ? r_idex.immd : w_fwd_b;
  assign w_sum   = w_fwd_a + w_alu_b;
  assign w_diff  = w_fwd_a - w_alu_b;
  assign w_slt   = $signed(w_fwd_a) < $signed(w_alu_b);
  assign w_eq    = w_fwd_a == w_fwd_b;
  assign w_alu   = r_idex.alu_op == OP_AND ? (w_fwd_a & w_alu_b) :
                   r_idex.alu_op == OP_OR  ? (w_fwd_a | w_alu_b) :
                   r_idex.alu_op == OP_ADD ? w_sum :
                   r_idex.alu_op == OP_SUB ? w_diff :
                   r_idex.alu_op == OP_SLT ? {{(DATA_W-1){1'b0}}, w_slt} :
                   r_idex.alu_op == OP_NOR ? ~(w_fwd_a | w_alu_b) : '0;
`ifdef EXEC_OVF_EN
  logic w_ovf;
  assign w_ovf = (r_idex.alu_op == OP_ADD && w_fwd_a[DATA_W-1] == w_alu_b[DATA_W-1] &&
                  w_sum[DATA_W-1] != w_fwd_a[DATA_W-1]) ||
                 (r_idex.alu_op == OP_SUB && w_fwd_a[DATA_W-1] != w_alu_b[DATA_W-1] &&
                  w_diff[DATA_W-1] != w_fwd_a[DATA_W-1]);
  always_ff @(posedge clk_87 or negedge rst_87)
    if (!rst_87) begin
      ovf_87          <= 1'b0;
      ex_reg_write_87 <= 1'b0;
    end else begin
      ovf_87          <= w_ovf;
      ex_reg_write_87 <= r_idex.reg_write && !w_ovf;
    end
`else
  assign ovf_87 = 1'b0;
  always_ff @(posedge clk_87 or negedge rst_87)
    if (!rst_87) ex_reg_write_87 <= 1'b0;
    else ex_reg_write_87 <= r_idex.reg_write;
`endif
  always_ff @(posedge clk_87 or negedge rst_87)
    if (!rst_87) begin
      ex_alu_result_87 <= '0;
      ex_store_data_87 <= '0;
      ex_wreg_87       <= '0;
      ex_mem_to_reg_87 <= 1'b0;
      ex_mem_read_87   <= 1'b0;
      ex_mem_write_87  <= 1'b0;
      ex_br_taken_87   <= 1'b0;
      ex_br_target_87  <= '0;
    end else begin
      ex_alu_result_87 <= w_alu;
      ex_store_data_87 <= w_fwd_b;
      ex_wreg_87       <= r_idex.wreg;
      ex_mem_to_reg_87 <= r_idex.mem_to_reg;
      ex_mem_read_87   <= r_idex.mem_read;
      ex_mem_write_87  <= r_idex.mem_write;
      ex_br_taken_87   <= r_idex.branch && w_eq;
      ex_br_target_87  <= r_idex.pc + ADDR_W'(r_idex.immd << 2);
    end
endmodule
